// File: rtl/ex_hazard_sequencer_if.sv
// ex_hazard_sequencer_if
//   Bundles the hazard inputs and the pipeline-register controls of the execute
//   stage sequencer.
//   Modports:
//     master - the sequencer: takes ID/EX/MEM hazard info, drives the register
//              enables, flushes, PC select and multi-cycle status.
//     slave  - the pipeline side: the opposite directions.
//   With HAZ_STATS_EN defined the bundle also carries the 32-bit stall, flush
//   and busy counters driven by the sequencer.
interface ex_hazard_sequencer_if;
    // ID / EX / MEM hazard information
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic [4:0] ex_rd;
    logic       ex_memread;
    logic       ex_branch_taken;
    logic       ex_multi_start;
    logic       mem_wait;
    // Pipeline register controls
    logic       pc_write;
    logic       ifid_write;
    logic       idex_write;
    logic       exmem_write;
    logic       ifid_flush;
    logic       idex_flush;
    logic       exmem_bubble;
    logic       pc_sel_branch;
    logic       ex_busy;
    logic       multi_done;
`ifdef HAZ_STATS_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
    logic [31:0] busy_cnt;
`endif

    modport master (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread,
               ex_branch_taken, ex_multi_start, mem_wait,
        output pc_write, ifid_write, idex_write, exmem_write, ifid_flush,
               idex_flush, exmem_bubble, pc_sel_branch, ex_busy, multi_done
`ifdef HAZ_STATS_EN
        , output stall_cnt, flush_cnt, busy_cnt
`endif
    );

    modport slave (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread,
               ex_branch_taken, ex_multi_start, mem_wait,
        input  pc_write, ifid_write, idex_write, exmem_write, ifid_flush,
               idex_flush, exmem_bubble, pc_sel_branch, ex_busy, multi_done
`ifdef HAZ_STATS_EN
        , input stall_cnt, flush_cnt, busy_cnt
`endif
    );
endinterface

// File: rtl/ex_hazard_sequencer.sv
// ex_hazard_sequencer
//   Execute-stage pipeline control. Each cycle decides whether PC, IF/ID, ID/EX
//   and EX/MEM advance, hold or take a bubble: memory wait freeze, taken-branch
//   redirect, multi-cycle EX sequencing (MULTI_LAT cycles) and load-use stall.
//   Ports:
//     clk      - core clock, rising edge
//     reset_n  - asynchronous active-low reset
//     hz       - ex_hazard_sequencer_if.master (hazard inputs, register controls)
//   Optional feature macro: HAZ_STATS_EN adds saturating stall/flush/busy
//   counters on the interface.
module ex_hazard_sequencer #(
    parameter int unsigned MULTI_LAT = 4,  // 2..16
    parameter int unsigned CW        = 4   // must hold MULTI_LAT-1
) (
    input logic                   clk,
    input logic                   reset_n,
    ex_hazard_sequencer_if.master hz
);

    localparam logic [0:0] StRun  = 1'b0;
    localparam logic [0:0] StBusy = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic load_use;
    logic pc_write, ifid_write, idex_write, exmem_write;
    logic ifid_flush, idex_flush, exmem_bubble, pc_sel_branch;
    logic ex_busy, multi_done;
    logic stall_evt, flush_evt;

    assign load_use = hz.ex_memread && (hz.ex_rd != 5'd0) &&
                      ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                       (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pc_write      = 1'b0;
        ifid_write    = 1'b0;
        idex_write    = 1'b0;
        exmem_write   = 1'b0;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        exmem_bubble  = 1'b0;
        pc_sel_branch = 1'b0;
        ex_busy       = 1'b0;
        multi_done    = 1'b0;
        stall_evt     = 1'b0;
        flush_evt     = 1'b0;
        // Outputs are forced quiet while reset is held, not just registered state.
        if (reset_n) begin
            unique case (state_q)
                StRun: begin
                    if (!hz.mem_wait) begin
                        pc_write    = 1'b1;
                        ifid_write  = 1'b1;
                        idex_write  = 1'b1;
                        exmem_write = 1'b1;
                        if (hz.ex_branch_taken) begin
                            pc_sel_branch = 1'b1;
                            ifid_flush    = 1'b1;
                            idex_flush    = 1'b1;
                            flush_evt     = 1'b1;
                        end else if (hz.ex_multi_start) begin
                            pc_write     = 1'b0;
                            ifid_write   = 1'b0;
                            idex_write   = 1'b0;
                            exmem_bubble = 1'b1;
                            ex_busy      = 1'b1;
                            state_d      = StBusy;
                            // Start cycle counts as the first of MULTI_LAT cycles.
                            cnt_d        = CW'(MULTI_LAT - 2);
                        end else if (load_use) begin
                            pc_write   = 1'b0;
                            ifid_write = 1'b0;
                            idex_flush = 1'b1;
                            stall_evt  = 1'b1;
                        end
                    end
                end
                StBusy: begin
                    ex_busy = 1'b1;
                    // A memory wait freezes everything and pauses the count.
                    if (!hz.mem_wait) begin
                        exmem_write = 1'b1;
                        if (cnt_q == '0) begin
                            multi_done = 1'b1;
                            idex_flush = 1'b1;  // keep the op from re-issuing
                            state_d    = StRun;
                        end else begin
                            exmem_bubble = 1'b1;
                            cnt_d        = cnt_q - CW'(1);
                        end
                    end
                end
                default: state_d = StRun;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StRun;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign hz.pc_write      = pc_write;
    assign hz.ifid_write    = ifid_write;
    assign hz.idex_write    = idex_write;
    assign hz.exmem_write   = exmem_write;
    assign hz.ifid_flush    = ifid_flush;
    assign hz.idex_flush    = idex_flush;
    assign hz.exmem_bubble  = exmem_bubble;
    assign hz.pc_sel_branch = pc_sel_branch;
    assign hz.ex_busy       = ex_busy;
    assign hz.multi_done    = multi_done;

`ifdef HAZ_STATS_EN
    logic [31:0] stall_cnt_q, flush_cnt_q, busy_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            busy_cnt_q  <= '0;
        end else if (!hz.mem_wait) begin
            if (stall_evt && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (flush_evt && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 32'd1;
            if (ex_busy && (busy_cnt_q != '1))    busy_cnt_q  <= busy_cnt_q + 32'd1;
        end
    end

    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;
    assign hz.busy_cnt  = busy_cnt_q;
`else
    // Event flags only feed the optional counters.
    logic unused_evt;
    assign unused_evt = stall_evt ^ flush_evt;
`endif

    // Branch and multi-cycle start in the same EX slot is illegal; branch wins.
    a_branch_multi_excl: assert property (@(posedge clk) disable iff (!reset_n)
        !((state_q == StRun) && !hz.mem_wait && hz.ex_branch_taken && hz.ex_multi_start));

endmodule

// File: tb/tb_ex_hazard_sequencer.sv
// tb_ex_hazard_sequencer
//   Directed self-checking bench for ex_hazard_sequencer (MULTI_LAT = 4).
//   Control outputs are packed as
//   {pc_write, ifid_write, idex_write, exmem_write,
//    ifid_flush, idex_flush, exmem_bubble, pc_sel_branch, ex_busy, multi_done}.
//   Inputs change 1 time unit after the rising edge; outputs are sampled on the
//   falling edge.
module tb_ex_hazard_sequencer;

    localparam logic [9:0] VRst   = 10'b0000_000_000;
    localparam logic [9:0] VIdle  = 10'b1111_000_000;
    localparam logic [9:0] VLu    = 10'b0011_010_000;
    localparam logic [9:0] VBr    = 10'b1111_110_100;
    localparam logic [9:0] VStart = 10'b0001_001_010;
    localparam logic [9:0] VBusy  = 10'b0001_001_010;
    localparam logic [9:0] VDone  = 10'b0001_010_011;
    localparam logic [9:0] VWait  = 10'b0000_000_000;
    localparam logic [9:0] VBWait = 10'b0000_000_010;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_fail;

    ex_hazard_sequencer_if hz_if ();

    ex_hazard_sequencer #(
        .MULTI_LAT (4),
        .CW        (4)
    ) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .hz      (hz_if)
    );

    logic [9:0] ctrl;
    assign ctrl = {hz_if.pc_write, hz_if.ifid_write, hz_if.idex_write, hz_if.exmem_write,
                   hz_if.ifid_flush, hz_if.idex_flush, hz_if.exmem_bubble,
                   hz_if.pc_sel_branch, hz_if.ex_busy, hz_if.multi_done};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Check the control vector at the falling edge, then step past the next rising edge.
    task automatic tick(input string tag, input logic [9:0] exp);
        @(negedge clk);
        check_eq(tag, {22'd0, ctrl}, {22'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        hz_if.id_rs1          = 5'd0;
        hz_if.id_rs2          = 5'd0;
        hz_if.id_use_rs1      = 1'b0;
        hz_if.id_use_rs2      = 1'b0;
        hz_if.ex_rd           = 5'd0;
        hz_if.ex_memread      = 1'b0;
        hz_if.ex_branch_taken = 1'b0;
        hz_if.ex_multi_start  = 1'b0;
        hz_if.mem_wait        = 1'b0;
    endtask

    task automatic set_lu(input logic [4:0] rd);
        hz_if.ex_memread = 1'b1;
        hz_if.ex_rd      = rd;
        hz_if.id_rs2     = rd;
        hz_if.id_use_rs2 = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        clr_in();
        reset_n = 1'b0;
        #3;
        check_eq("reset_hold", {22'd0, ctrl}, {22'd0, VRst});
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        tick("idle0", VIdle);
        tick("idle1", VIdle);

        // Load-use on rs2, then on rs1; the stall lasts one cycle only.
        set_lu(5'd5);
        tick("lu_rs2", VLu);
        clr_in();
        tick("lu_one_cycle", VIdle);
        hz_if.ex_memread = 1'b1;
        hz_if.ex_rd      = 5'd7;
        hz_if.id_rs1     = 5'd7;
        hz_if.id_use_rs1 = 1'b1;
        hz_if.id_rs2     = 5'd3;
        hz_if.id_use_rs2 = 1'b1;
        tick("lu_rs1", VLu);
        clr_in();
        set_lu(5'd0);
        tick("lu_rd0", VIdle);
        clr_in();
        set_lu(5'd9);
        hz_if.id_use_rs2 = 1'b0;
        tick("lu_unused", VIdle);
        clr_in();
        set_lu(5'd5);
        hz_if.ex_memread = 1'b0;
        tick("lu_noload", VIdle);

        // Branch beats a coincident load-use; PC keeps advancing.
        clr_in();
        set_lu(5'd5);
        hz_if.ex_branch_taken = 1'b1;
        tick("br_lu", VBr);
        clr_in();

        // Multi-cycle op; branch and load-use in BUSY are ignored.
        hz_if.ex_multi_start = 1'b1;
        tick("mul_c1", VStart);
        clr_in();
        hz_if.ex_branch_taken = 1'b1;
        tick("mul_c2", VBusy);
        clr_in();
        set_lu(5'd5);
        tick("mul_c3", VBusy);
        clr_in();
        tick("mul_c4_done", VDone);
        tick("mul_after", VIdle);

        // Two wait cycles in BUSY delay multi_done by exactly two cycles.
        hz_if.ex_multi_start = 1'b1;
        tick("mw_c1", VStart);
        clr_in();
        tick("mw_c2", VBusy);
        hz_if.mem_wait = 1'b1;
        tick("mw_wait1", VBWait);
        tick("mw_wait2", VBWait);
        hz_if.mem_wait = 1'b0;
        tick("mw_c3", VBusy);
        tick("mw_done", VDone);
        tick("mw_after", VIdle);

        // Back-to-back multi-cycle ops.
        hz_if.ex_multi_start = 1'b1;
        tick("b2b_a1", VStart);
        hz_if.ex_multi_start = 1'b0;
        tick("b2b_a2", VBusy);
        tick("b2b_a3", VBusy);
        tick("b2b_a_done", VDone);
        hz_if.ex_multi_start = 1'b1;
        tick("b2b_b1", VStart);
        hz_if.ex_multi_start = 1'b0;
        tick("b2b_b2", VBusy);
        tick("b2b_b3", VBusy);
        tick("b2b_b_done", VDone);
        tick("b2b_after", VIdle);

        // mem_wait in RUN freezes and blocks entry to BUSY.
        hz_if.ex_multi_start = 1'b1;
        hz_if.mem_wait       = 1'b1;
        tick("run_wait", VWait);
        clr_in();
        tick("run_wait_no_busy", VIdle);

        // Reset asserted mid-BUSY.
        hz_if.ex_multi_start = 1'b1;
        tick("rb_c1", VStart);
        clr_in();
        tick("rb_c2", VBusy);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("rb_async", {22'd0, ctrl}, {22'd0, VRst});
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick("rb_run0", VIdle);
        tick("rb_run1", VIdle);
        tick("rb_run2", VIdle);
`ifdef HAZ_STATS_EN
        check_eq("stats_rst_stall", hz_if.stall_cnt, 32'd0);
        check_eq("stats_rst_flush", hz_if.flush_cnt, 32'd0);
        check_eq("stats_rst_busy", hz_if.busy_cnt, 32'd0);
`endif

        // Event mix for the optional counters.
        set_lu(5'd4);
        tick("st_lu", VLu);
        clr_in();
        hz_if.ex_branch_taken = 1'b1;
        tick("st_br", VBr);
        clr_in();
        set_lu(5'd4);
        hz_if.mem_wait = 1'b1;
        tick("st_wait_lu", VWait);
        clr_in();
        hz_if.ex_multi_start = 1'b1;
        tick("st_m1", VStart);
        clr_in();
        tick("st_m2", VBusy);
        hz_if.mem_wait = 1'b1;
        tick("st_mw", VBWait);
        hz_if.mem_wait = 1'b0;
        tick("st_m3", VBusy);
        tick("st_mdone", VDone);
        tick("st_after", VIdle);
`ifdef HAZ_STATS_EN
        check_eq("stats_stall", hz_if.stall_cnt, 32'd1);
        check_eq("stats_flush", hz_if.flush_cnt, 32'd1);
        check_eq("stats_busy", hz_if.busy_cnt, 32'd4);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_hazard_sequencer.md
# ex_hazard_sequencer

Pipeline control block for the execute stage. Decides each cycle whether the PC, IF/ID, ID/EX and EX/MEM pipeline registers advance, hold or take a bubble. It resolves load-use hazards, taken-branch redirects and memory wait requests. It also sequences multi-cycle EX operations such as mul/div, holding the ALU stage for a fixed latency. It sits beside the forwarding unit and drives the write-enable and flush inputs of the pipeline registers and the PC select mux.

## Interface
Parameters:
- MULTI_LAT, 4: cycles a multi-cycle EX operation occupies EX (legal range 2..16).
- CW, 4: width of the busy counter (must hold MULTI_LAT-1).

Ports:
- clk  in  1  core clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- id_rs1, id_rs2  in  5  source registers of the instruction in ID.
- id_use_rs1, id_use_rs2  in  1  the ID instruction actually reads rs1/rs2.
- ex_rd  in  5  destination of the instruction in EX.
- ex_memread  in  1  instruction in EX is a load.
- ex_branch_taken  in  1  branch in EX resolved taken (branch & zero, or jump).
- ex_multi_start  in  1  instruction in EX is a multi-cycle op, first EX cycle.
- mem_wait  in  1  data memory not ready; freeze the whole pipeline.
- pc_write, ifid_write, idex_write, exmem_write  out  1  register enables.
- ifid_flush, idex_flush, exmem_bubble  out  1  insert NOP into the named register.
- pc_sel_branch  out  1  select the branch address as the next PC.
- ex_busy  out  1  multi-cycle op in progress.
- multi_done  out  1  last cycle of a multi-cycle op; its result is valid on ALUresult.

## Operation
- FSM states: RUN, BUSY. Counter cnt[CW-1:0].
- All outputs are combinational from the state, cnt and inputs. The default in RUN is all enables=1, flushes=0, pc_sel_branch=0.
- Priority in RUN, highest first:
  1. mem_wait: all four enables=0, all flushes=0, pc_sel_branch=0; state and cnt unchanged.
  2. ex_branch_taken: pc_sel_branch=1, ifid_flush=1, idex_flush=1.
  3. ex_multi_start: pc_write=ifid_write=idex_write=0, exmem_bubble=1, ex_busy=1; next state BUSY, cnt<=MULTI_LAT-2.
  4. Load-use: the hazard exists when ex_memread=1, ex_rd!=0, and (id_use_rs1 & id_rs1==ex_rd) or (id_use_rs2 & id_rs2==ex_rd). Response: pc_write=0, ifid_write=0, idex_flush=1. It lasts exactly one cycle and needs no state.
- BUSY state:
  - pc_write=ifid_write=idex_write=0, exmem_bubble=1, ex_busy=1.
  - cnt decrements each non-waiting cycle.
  - When cnt==0: multi_done=1, exmem_write=1, exmem_bubble=0, idex_flush=1 so the op is not re-issued; next state RUN.
- In BUSY, ex_branch_taken, ex_multi_start and load-use are ignored because ID and EX are frozen.
- mem_wait in BUSY: freezes all enables and pauses cnt; multi_done stays 0 until the wait clears.
- ex_branch_taken together with ex_multi_start is illegal (one EX instruction). Branch wins; a simulation assertion flags it.

## Timing
- Reset (reset_n=0, async): state=RUN, cnt=0. While reset is low, all enables=0, all flushes/bubbles=0, pc_sel_branch=0, ex_busy=0, multi_done=0. The first cycle after release behaves as RUN.
- Reset asserted mid-BUSY: returns to RUN immediately; no multi_done is produced.
- Load-use: 1 bubble cycle.
- Taken branch: 2 instructions flushed, redirect in the same cycle.
- Multi-cycle op: EX is occupied for exactly MULTI_LAT cycles, the start cycle plus MULTI_LAT-1 BUSY cycles, with no mem_wait. multi_done asserts in cycle MULTI_LAT counting the start cycle as 1.
- Back-to-back multi-cycle ops: the second starts in the cycle after multi_done, once it reaches EX, with no dead cycle beyond normal advance.

## Configuration
- HAZ_STATS_EN defined: adds outputs stall_cnt[31:0], flush_cnt[31:0] and busy_cnt[31:0].
  - stall_cnt increments per load-use cycle; flush_cnt per taken branch; busy_cnt per cycle with ex_busy=1.
  - All three reset to 0, saturate at 2^32-1 and do not count while mem_wait=1.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

## Test plan
- Reset release, idle RUN, no hazards: all four enables=1, flushes=0, ex_busy=0 every cycle.
- Load-use: ex_memread=1, ex_rd=5, id_rs2=5, id_use_rs2=1. Expect one cycle with pc_write=0, ifid_write=0, idex_flush=1. Repeat with ex_rd=0: no stall.
- Taken branch coincident with a load-use match: pc_sel_branch=1, ifid_flush=1, idex_flush=1, and pc_write stays 1.
- ex_multi_start pulse with MULTI_LAT=4: ex_busy high for 4 cycles, multi_done only in the 4th, exmem_write=1 in that cycle, then RUN.
- MULTI_LAT=4 with mem_wait=1 for 2 cycles in BUSY: multi_done delayed by exactly 2 cycles and all enables=0 during the wait.
- reset_n pulsed low during BUSY: outputs go to reset values asynchronously, multi_done never asserts, and RUN resumes after release. With HAZ_STATS_EN, counters read 0.
